// File: rtl/aes_enc_seq_pkg.sv
// Shared AES constants, FSM encoding and byte-level cipher helpers.
// Used by the round datapath, the key schedule and the sequencer.
package aes_enc_seq_pkg;

    localparam int Nb     = 4;
    localparam int BlockW = 128;

    localparam int Nk128 = 4;
    localparam int Nr128 = 10;
    localparam int Nk192 = 6;
    localparam int Nr192 = 12;
    localparam int Nk256 = 8;
    localparam int Nr256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsmState_t;

    function automatic logic legalKeyCfg(input int nk, input int nr);
        return (nk == Nk128 && nr == Nr128) ||
               (nk == Nk192 && nr == Nr192) ||
               (nk == Nk256 && nr == Nr256);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [BlockW-1:0] subBytes(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte 0 is the MSB; column c holds bytes 4c..4c+3 (row = index % 4).
    function automatic logic [BlockW-1:0] shiftRows(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BlockW-1:0] mixColumns(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_enc_seq_round.sv
// Combinational AES round datapath and key schedule.
// Round primitives are thin wrappers so aes_round composes them structurally.
module SubBytes
    import aes_enc_seq_pkg::*;
(
    input  logic [BlockW-1:0] stateIn,
    output logic [BlockW-1:0] stateOut
);
    assign stateOut = subBytes(stateIn);
endmodule

module ShiftRows
    import aes_enc_seq_pkg::*;
(
    input  logic [BlockW-1:0] stateIn,
    output logic [BlockW-1:0] stateOut
);
    assign stateOut = shiftRows(stateIn);
endmodule

module MixColumns
    import aes_enc_seq_pkg::*;
(
    input  logic [BlockW-1:0] stateIn,
    output logic [BlockW-1:0] stateOut
);
    assign stateOut = mixColumns(stateIn);
endmodule

module AddRoundKey
    import aes_enc_seq_pkg::*;
(
    input  logic [BlockW-1:0] stateIn,
    input  logic [BlockW-1:0] roundKey,
    output logic [BlockW-1:0] stateOut
);
    assign stateOut = stateIn ^ roundKey;
endmodule

module KeyExpansion
    import aes_enc_seq_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [Nk*32-1:0]  key,
    output logic [BlockW-1:0] roundKeys [Nr+1]
);
    localparam int NumWords = Nb * (Nr + 1);

    logic [31:0] w [NumWords];
    logic [31:0] temp;
    logic [7:0]  rcon;

    always_comb begin
        temp = '0;
        rcon = 8'h01;
        for (int i = 0; i < Nk; i++) w[i] = key[32*(Nk-1-i) +: 32];
        for (int i = Nk; i < NumWords; i++) begin
            temp = w[i-1];
            if (i % Nk == 0) begin
                temp = subWord(rotWord(temp)) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                temp = subWord(temp);
            end
            w[i] = w[i-Nk] ^ temp;
        end
        for (int r = 0; r <= Nr; r++) begin
            roundKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end
endmodule

module aes_round
    import aes_enc_seq_pkg::*;
(
    input  logic [BlockW-1:0] state,
    input  logic [BlockW-1:0] roundKey,
    input  logic              isFirst,
    input  logic              isLast,
    output logic [BlockW-1:0] result
);
    logic [BlockW-1:0] sb, sr, mc, pre;

    SubBytes    uSub (.stateIn(state), .stateOut(sb));
    ShiftRows   uShf (.stateIn(sb),    .stateOut(sr));
    MixColumns  uMix (.stateIn(sr),    .stateOut(mc));

    // Initial round is whitening only; final round drops MixColumns.
    assign pre = isFirst ? state : (isLast ? sr : mc);

    AddRoundKey uArk (.stateIn(pre), .roundKey(roundKey), .stateOut(result));
endmodule

// File: rtl/aes_enc_seq.sv
// Iterative AES encryptor: one round per clock through a shared datapath,
// valid/ready on both sides, key schedule derived from the latched key.
module aes_enc_seq
    import aes_enc_seq_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BlockW-1:0] data_in,
    input  logic [Nk*32-1:0]  key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BlockW-1:0] data_out,
    output logic              busy
);
    localparam int CntW = $clog2(Nr + 1);
    localparam logic [CntW-1:0] LastRound = CntW'(Nr);

    if (!legalKeyCfg(Nk, Nr)) begin : gBadCfg
        $error("aes_enc_seq: illegal Nk/Nr combination");
    end

    fsmState_t         state;
    logic [BlockW-1:0] stateReg;
    logic [Nk*32-1:0]  keyReg;
    logic [CntW-1:0]   round;
    logic [BlockW-1:0] roundKeys [Nr+1];
    logic [BlockW-1:0] nextState;

    KeyExpansion #(.Nk(Nk), .Nr(Nr)) uKeyExp (
        .key       (keyReg),
        .roundKeys (roundKeys)
    );

    aes_round uRound (
        .state    (stateReg),
        .roundKey (roundKeys[round]),
        .isFirst  (round == '0),
        .isLast   (round == LastRound),
        .result   (nextState)
    );

    // All outputs read as idle/zero while reset is asserted.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign busy      = (state != IDLE) && !rst;
    assign data_out  = rst ? '0 : stateReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            round    <= '0;
            stateReg <= '0;
            keyReg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        stateReg <= data_in;
                        keyReg   <= key_in;
                        round    <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    stateReg <= nextState;
                    if (round == LastRound) state <= DONE;
                    else round <= round + 1'b1;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
